// File: rtl/bcd_pkg.sv
// Shared BCD limits, seven-segment patterns {g,f,e,d,c,b,a} and the digit decoder
// used by the multi-digit counter and its digit slices.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Active-high decode; non-BCD codes blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple chain: loadable, steps up or down when every lower
// digit sits at its limit (carry_i/borrow_i), and passes that condition upward.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       en_i,
  input  logic       up_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       carry_i,
  input  logic       borrow_i,
  output logic [3:0] digit_o,
  output logic       carry_o,
  output logic       borrow_o
);

  logic [3:0] digit_q, digit_d;
  logic       at_max, at_min;

  // Out-of-range codes wrap in whichever direction the step goes.
  assign at_max   = (digit_q >= BCD_MAX);
  assign at_min   = (digit_q == BCD_MIN) || (digit_q > BCD_MAX);
  assign carry_o  = carry_i  & at_max;
  assign borrow_o = borrow_i & at_min;
  assign digit_o  = digit_q;

  // NOTE: every path assigns digit_d a default first, so no latch is inferred.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (en_i && up_i && carry_i) begin
      digit_d = at_max ? BCD_MIN : digit_q + 4'd1;
    end else if (en_i && !up_i && borrow_i) begin
      digit_d = at_min ? BCD_MAX : digit_q - 4'd1;
    end
  end

  // NOTE: state uses non-blocking assignment; reset is synchronous, so rstn is
  // only looked at inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rstn) digit_q <= BCD_MIN;
    else       digit_q <= digit_d;
  end

endmodule

// File: rtl/bcd_multidigit_counter.sv
// N-digit BCD up/down counter with validated preset load, terminal-count pulse
// and a time-multiplexed seven-segment scan driving one shared segment bus.
module bcd_multidigit_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 16,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  enter,
  input  logic [4*DIGITS-1:0]   load,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  load_err,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [6:0]        SEG_POL = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [DIGITS-1:0] AN_POL  = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [4*DIGITS-1:0] count_w;
  logic [DIGITS:0]     carry, borrow;
  logic                load_ok, load_en, step_en, wrap;

  logic              tc_q, load_err_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        scan_digit;

  always_comb begin
    load_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (load[4*k +: 4] > BCD_MAX) load_ok = 1'b0;
    end
  end

  // enter outranks en even when the preset is rejected.
  assign load_en   = enter & load_ok;
  assign step_en   = en & ~enter;
  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;
  assign wrap      = step_en & (mode ? carry[DIGITS] : borrow[DIGITS]);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rstn       (rstn),
      .en_i       (step_en),
      .up_i       (mode),
      .load_i     (load_en),
      .load_val_i (load[4*g +: 4]),
      .carry_i    (carry[g]),
      .borrow_i   (borrow[g]),
      .digit_o    (count_w[4*g +: 4]),
      .carry_o    (carry[g+1]),
      .borrow_o   (borrow[g+1])
    );
  end

  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    scan_digit = '0;
    an_d       = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        scan_digit = count_w[4*k +: 4];
        an_d[k]    = 1'b1;
      end
    end
    seg_d = seg_decode(scan_digit) ^ SEG_POL;
    an_d  = an_d ^ AN_POL;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
      div_q      <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_0 ^ SEG_POL;
      an_q       <= DIGITS'(1) ^ AN_POL;
    end else begin
      tc_q       <= wrap;
      load_err_q <= enter & ~load_ok;
      div_q      <= div_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign count    = count_w;
  assign tc       = tc_q;
  assign load_err = load_err_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule
